// File: rtl/eth_tx_pkg.sv
// rtl/eth_tx_pkg.sv - shared FSM encoding and default constants for the transmit frame buffer
package eth_tx_pkg;

    localparam int ETH_MIN_LEN = 60;
    localparam int ETH_LEN_W   = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STREAM = 3'd2,
        PAD    = 3'd3,
        GAP    = 3'd4
    } tx_state_e;

endpackage

// File: rtl/eth_tx_frame_buffer_if.sv
// rtl/eth_tx_frame_buffer_if.sv - host write side and MAC read side of the transmit frame buffer
interface eth_tx_frame_buffer_if
    import eth_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = ETH_LEN_W,
    parameter int DESC_AW = 4
);
    logic              data_wr_i;
    logic [DATA_W-1:0] data_i;
    logic              len_wr_i;
    logic [LEN_W-1:0]  len_i;
    logic              ovf_clr_i;
    logic              data_full_o;
    logic              desc_full_o;
    logic              overflow_o;
    logic [DESC_AW:0]  frames_pending_o;
    logic              tx_macread;
    logic [DATA_W-1:0] tx_fifodata;
    logic              tx_fifoempty;
    logic              tx_fifoeof;

    modport master (
        output data_wr_i, data_i, len_wr_i, len_i, ovf_clr_i, tx_macread,
        input  data_full_o, desc_full_o, overflow_o, frames_pending_o,
               tx_fifodata, tx_fifoempty, tx_fifoeof
    );

    modport slave (
        input  data_wr_i, data_i, len_wr_i, len_i, ovf_clr_i, tx_macread,
        output data_full_o, desc_full_o, overflow_o, frames_pending_o,
               tx_fifodata, tx_fifoempty, tx_fifoeof
    );

endinterface

// File: rtl/eth_sync_fifo.sv
// rtl/eth_sync_fifo.sv - single-clock show-ahead FIFO with full/empty/occupancy
module eth_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk_i,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam int          DEPTH      = 1 << AW;
    localparam logic [AW:0] FULL_COUNT = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees the slot in the same cycle, so a push at full is accepted
    // only when paired with a pop.
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/eth_tx_frame_buffer.sv
// rtl/eth_tx_frame_buffer.sv - transmit frame buffer between host writes and the MAC read port
module eth_tx_frame_buffer
    import eth_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int DATA_AW = 10,
    parameter int LEN_W   = ETH_LEN_W,
    parameter int DESC_AW = 4,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int PAD_EN  = 1
) (
    input  logic clk_i,
    input  logic reset_n,
    input  logic clk_en,
    eth_tx_frame_buffer_if.slave bus
);
    localparam logic [LEN_W-1:0] MIN_LEN_C = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    tx_state_e         state;
    tx_state_e         state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rem_cnt;
    logic [LEN_W-1:0]  pad_cnt;
    logic [LEN_W-1:0]  pad_calc;

    logic [DATA_W-1:0] data_head;
    logic              data_full;
    logic              data_empty;
    logic [DATA_AW:0]  data_count;
    logic [LEN_W-1:0]  desc_head;
    logic              desc_full;
    logic              desc_empty;
    logic [DESC_AW:0]  desc_count;

    logic              data_push;
    logic              data_pop;
    logic              desc_push;
    logic              desc_pop;
    logic              data_drop;
    logic              desc_drop;
    logic              tx_read;
    logic              tx_empty;
    logic              tx_eof;
    logic [DATA_W-1:0] tx_data;
    logic              overflow_q;
    logic              unused_data_count;

    assign unused_data_count = ^data_count;

    // Everything is qualified by clk_en so that a low enable freezes all state.
    assign data_push = clk_en && bus.data_wr_i;
    assign desc_push = clk_en && bus.len_wr_i;
    assign tx_read   = clk_en && bus.tx_macread && !tx_empty;
    assign data_pop  = tx_read && (state == STREAM);
    assign desc_pop  = clk_en && (state == IDLE) && !desc_empty;
    assign data_drop = data_push && data_full && !data_pop;
    assign desc_drop = desc_push && desc_full && !desc_pop;

    // Lengths below the minimum are topped up with zero words when padding is on.
    assign pad_calc = ((PAD_EN != 0) && (len_q < MIN_LEN_C)) ? (MIN_LEN_C - len_q) : '0;

    eth_sync_fifo #(
        .WIDTH (DATA_W),
        .AW    (DATA_AW)
    ) u_data_fifo (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .wr_en   (data_push),
        .wr_data (bus.data_i),
        .rd_en   (data_pop),
        .rd_data (data_head),
        .full    (data_full),
        .empty   (data_empty),
        .count   (data_count)
    );

    eth_sync_fifo #(
        .WIDTH (LEN_W),
        .AW    (DESC_AW)
    ) u_desc_fifo (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .wr_en   (desc_push),
        .wr_data (bus.len_i),
        .rd_en   (desc_pop),
        .rd_data (desc_head),
        .full    (desc_full),
        .empty   (desc_empty),
        .count   (desc_count)
    );

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_nxt;
        end
    end

    // FSM next-state: fetch descriptor, load counters, stream data, pad, inter-frame gap
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!desc_empty) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = (len_q == '0) ? GAP : STREAM;
            end
            STREAM: begin
                if (tx_read && (rem_cnt == LEN_ONE)) begin
                    state_nxt = (pad_cnt != '0) ? PAD : GAP;
                end
            end
            PAD: begin
                if (tx_read && (pad_cnt == LEN_ONE)) begin
                    state_nxt = GAP;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM outputs towards the MAC: FIFO head in STREAM, zero words in PAD, empty otherwise
    always_comb begin
        tx_empty = 1'b1;
        tx_eof   = 1'b0;
        tx_data  = '0;
        case (state)
            STREAM: begin
                tx_empty = data_empty;
                tx_data  = data_head;
                tx_eof   = (rem_cnt == LEN_ONE) && (pad_cnt == '0) && !data_empty;
            end
            PAD: begin
                tx_empty = 1'b0;
                tx_eof   = (pad_cnt == LEN_ONE);
            end
            default: begin
                tx_empty = 1'b1;
            end
        endcase
    end

    // Frame counters: descriptor captured on pop, loaded in LOAD, counted down per word
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            len_q   <= '0;
            rem_cnt <= '0;
            pad_cnt <= '0;
        end else if (clk_en) begin
            if (desc_pop) begin
                len_q <= desc_head;
            end
            if (state == LOAD) begin
                rem_cnt <= len_q;
                pad_cnt <= pad_calc;
            end else if ((state == STREAM) && tx_read) begin
                rem_cnt <= rem_cnt - LEN_ONE;
            end else if ((state == PAD) && tx_read) begin
                pad_cnt <= pad_cnt - LEN_ONE;
            end
        end
    end

    // Sticky overflow: a dropped write wins over a clear in the same cycle
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
        end else if (clk_en) begin
            if (data_drop || desc_drop) begin
                overflow_q <= 1'b1;
            end else if (bus.ovf_clr_i) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bus.tx_fifodata      = tx_data;
    assign bus.tx_fifoempty     = tx_empty;
    assign bus.tx_fifoeof       = tx_eof;
    assign bus.data_full_o      = data_full;
    assign bus.desc_full_o      = desc_full;
    assign bus.overflow_o       = overflow_q;
    assign bus.frames_pending_o = desc_count;

endmodule

// File: tb/tb_eth_tx_frame_buffer.sv
// tb/tb_eth_tx_frame_buffer.sv - self-checking bench for the transmit frame buffer
module tb_eth_tx_frame_buffer;

    localparam int DATA_W  = 8;
    localparam int DATA_AW = 10;
    localparam int LEN_W   = 16;
    localparam int DESC_AW = 4;
    localparam int MIN_LEN = 60;
    localparam int PAD_EN  = 1;
    localparam int DEPTH   = 1 << DATA_AW;

    logic clk_i   = 1'b0;
    logic reset_n = 1'b1;
    logic clk_en  = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    eth_tx_frame_buffer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DESC_AW(DESC_AW)) bus ();

    eth_tx_frame_buffer #(
        .DATA_W (DATA_W), .DATA_AW (DATA_AW), .LEN_W (LEN_W),
        .DESC_AW(DESC_AW), .MIN_LEN (MIN_LEN), .PAD_EN (PAD_EN)
    ) dut (
        .clk_i   (clk_i),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: bytes accepted into the buffer, committed lengths, and the
    // word slots (data or pad, with eof flag) of the frame currently being read.
    typedef struct packed { logic is_pad; logic eof; } slot_t;
    logic [7:0] byte_q [$];
    int         len_q  [$];
    slot_t      exp_q  [$];
    int         frame_words = 0;
    int         last_frame_len = 0;
    int         eof_cnt = 0;
    int         gap_cnt = 0;
    bit         in_gap = 0;

    function automatic void expand_frame();
        while (exp_q.size() == 0 && len_q.size() > 0) begin
            int l;
            int total;
            l = len_q.pop_front();
            if (l == 0) continue;
            total = (PAD_EN != 0 && l < MIN_LEN) ? MIN_LEN : l;
            for (int i = 0; i < total; i++) begin
                exp_q.push_back('{is_pad: (i >= l), eof: (i == total - 1)});
            end
        end
    endfunction

    function automatic int remaining();
        int r;
        r = exp_q.size() + byte_q.size();
        foreach (len_q[i]) r += len_q[i];
        return r;
    endfunction

    // Scoreboard sampled on the falling edge, mid-cycle
    always @(negedge clk_i) begin
        bit         rd;
        bit         dpop;
        int         occ;
        slot_t      s;
        logic [7:0] exp_d;
        if (!reset_n) begin
            byte_q.delete();
            len_q.delete();
            exp_q.delete();
            frame_words = 0;
            in_gap = 0;
        end else if (clk_en) begin
            rd   = bus.tx_macread && !bus.tx_fifoempty;
            dpop = 0;
            occ  = byte_q.size();
            if (in_gap && !bus.tx_fifoempty) begin
                check("frame_gap_ge_3", (gap_cnt >= 3), 1);
                in_gap = 0;
            end else if (in_gap) begin
                gap_cnt++;
            end
            if (rd) begin
                expand_frame();
                check("word_expected", (exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    s = exp_q.pop_front();
                    exp_d = 8'h00;
                    if (!s.is_pad) begin
                        check("data_available", (byte_q.size() > 0), 1);
                        if (byte_q.size() > 0) exp_d = byte_q.pop_front();
                        dpop = 1;
                    end
                    check("tx_fifodata", bus.tx_fifodata, exp_d);
                    check("tx_fifoeof", bus.tx_fifoeof, s.eof);
                    frame_words++;
                    if (s.eof) begin
                        last_frame_len = frame_words;
                        frame_words = 0;
                        eof_cnt++;
                        in_gap = 1;
                        gap_cnt = 0;
                    end
                end
            end
            if (bus.data_wr_i && (occ < DEPTH || dpop)) byte_q.push_back(bus.data_i);
            if (bus.len_wr_i) len_q.push_back(int'(bus.len_i));
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        clk_en = 1'b1;
        bus.data_wr_i = 1'b1;
        bus.data_i = b;
        tick();
        bus.data_wr_i = 1'b0;
    endtask

    task automatic commit(input int l);
        clk_en = 1'b1;
        bus.len_wr_i = 1'b1;
        bus.len_i = LEN_W'(l);
        tick();
        bus.len_wr_i = 1'b0;
    endtask

    task automatic drain(input int budget);
        int start;
        start = eof_cnt;
        clk_en = 1'b1;
        bus.tx_macread = 1'b1;
        for (int c = 0; c < budget && eof_cnt == start; c++) tick();
        bus.tx_macread = 1'b0;
    endtask

    task automatic pulse_reset();
        bus.tx_macread = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    typedef struct { int nbytes; int len; int exp_words; } vec_t;
    vec_t tbl [7];

    initial begin
        int w0;
        int e0;
        int bad;
        int nz;
        bit ok;
        bus.data_wr_i = 0; bus.data_i = 0; bus.len_wr_i = 0; bus.len_i = 0;
        bus.ovf_clr_i = 0; bus.tx_macread = 0;
        #1 reset_n = 1'b0;
        tick(); tick();
        check("rst_empty", bus.tx_fifoempty, 1);
        check("rst_eof", bus.tx_fifoeof, 0);
        check("rst_data", bus.tx_fifodata, 0);
        check("rst_overflow", bus.overflow_o, 0);
        check("rst_data_full", bus.data_full_o, 0);
        check("rst_desc_full", bus.desc_full_o, 0);
        check("rst_pending", bus.frames_pending_o, 0);
        reset_n = 1'b1;
        tick();

        // clk_en low: a write and a commit are both ignored
        clk_en = 1'b0; bus.data_wr_i = 1; bus.data_i = 8'h77; bus.len_wr_i = 1; bus.len_i = 3;
        tick();
        bus.data_wr_i = 0; bus.len_wr_i = 0; clk_en = 1'b1;
        tick();
        check("clken_pending", bus.frames_pending_o, 0);
        check("clken_empty", bus.tx_fifoempty, 1);

        // table-driven frames: bytes written, length committed, words delivered
        tbl = '{'{64, 64, 64}, '{10, 10, 60}, '{1, 1, 60}, '{59, 59, 60},
                '{60, 60, 60}, '{61, 61, 61}, '{0, 0, 0}};
        for (int i = 0; i < 7; i++) begin
            for (int b = 0; b < tbl[i].nbytes; b++) write_byte(8'(b + i * 16));
            commit(tbl[i].len);
            w0 = eof_cnt;
            e0 = last_frame_len;
            drain(tbl[i].exp_words == 0 ? 10 : tbl[i].exp_words + 20);
            check("vec_frames", eof_cnt - w0, (tbl[i].exp_words > 0) ? 1 : 0);
            if (eof_cnt != w0) check("vec_words", last_frame_len, tbl[i].exp_words);
            for (int k = 0; k < 3; k++) begin
                check("vec_trailing_empty", bus.tx_fifoempty, 1);
                tick();
            end
        end

        // descriptor-to-first-word latency
        for (int b = 0; b < 4; b++) write_byte(8'hA0 + 8'(b));
        commit(4);
        check("lat_idle_empty", bus.tx_fifoempty, 1);
        check("lat_idle_pending", bus.frames_pending_o, 1);
        tick();
        check("lat_load_empty", bus.tx_fifoempty, 1);
        check("lat_load_pending", bus.frames_pending_o, 0);
        tick();
        check("lat_stream_empty", bus.tx_fifoempty, 0);
        check("lat_stream_data", bus.tx_fifodata, 8'hA0);
        check("lat_stream_eof", bus.tx_fifoeof, 0);
        drain(90);
        check("lat_words", last_frame_len, 60);

        // zero-length descriptor discarded between two real frames
        write_byte(8'h11); write_byte(8'h12);
        commit(2);
        for (int k = 0; k < 4; k++) tick();
        commit(0);
        commit(4);
        for (int b = 0; b < 4; b++) write_byte(8'hC0 + 8'(b));
        check("zl_pending2", bus.frames_pending_o, 2);
        clk_en = 1'b1;
        bus.tx_macread = 1'b1;
        ok = 0;
        for (int c = 0; c < 300; c++) begin
            if (bus.frames_pending_o == 1) begin ok = 1; break; end
            tick();
        end
        check("zl_pending1", ok, 1);
        ok = 0;
        for (int c = 0; c < 50; c++) begin
            if (bus.frames_pending_o == 0) begin ok = 1; break; end
            tick();
        end
        check("zl_pending0", ok, 1);
        drain(100);
        check("zl_words", last_frame_len, 60);

        // underrun: three bytes present, remaining five arrive later
        for (int b = 0; b < 3; b++) write_byte(8'h51 + 8'(b));
        commit(8);
        bus.tx_macread = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("ur_words_before", frame_words, 3);
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if (!bus.tx_fifoempty) bad++;
            tick();
        end
        check("ur_stall_empty", bad, 0);
        for (int b = 0; b < 5; b++) write_byte(8'h54 + 8'(b));
        drain(100);
        check("ur_words", last_frame_len, 60);

        // reset in the middle of a frame
        for (int b = 0; b < 20; b++) write_byte(8'(b * 3));
        commit(20);
        commit(5);
        bus.tx_macread = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        bus.tx_macread = 1'b0;
        check("mid_pending", bus.frames_pending_o, 1);
        check("mid_streaming", bus.tx_fifoempty, 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_empty", bus.tx_fifoempty, 1);
        check("mid_rst_eof", bus.tx_fifoeof, 0);
        check("mid_rst_pending", bus.frames_pending_o, 0);
        tick();
        reset_n = 1'b1;
        for (int b = 0; b < 6; b++) write_byte(8'hE0 + 8'(b));
        commit(6);
        drain(100);
        check("post_rst_words", last_frame_len, 60);

        // fill the data FIFO, overflow, set-dominance, clear, push+pop at full
        for (int b = 0; b < DEPTH - 1; b++) write_byte(8'(b));
        check("fill_not_full", bus.data_full_o, 0);
        write_byte(8'hFF);
        check("fill_full", bus.data_full_o, 1);
        check("fill_no_ovf", bus.overflow_o, 0);
        write_byte(8'h5A);
        check("ovf_set", bus.overflow_o, 1);
        bus.ovf_clr_i = 1'b1;
        write_byte(8'h5B);
        check("ovf_set_dominant", bus.overflow_o, 1);
        tick();
        bus.ovf_clr_i = 1'b0;
        check("ovf_cleared", bus.overflow_o, 0);
        commit(DEPTH);
        tick(); tick();
        bus.tx_macread = 1'b1;
        write_byte(8'h3C);
        check("full_pushpop_no_ovf", bus.overflow_o, 0);
        check("full_pushpop_full", bus.data_full_o, 1);
        drain(DEPTH + 50);
        check("full_frame_words", last_frame_len, DEPTH);
        pulse_reset();

        // randomized frames with random enable, read and write activity
        nz = 0;
        e0 = eof_cnt;
        for (int f = 0; f < 25; f++) begin
            int l;
            int sent;
            bit cfirst;
            l = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 90));
            if (l != 0) nz++;
            cfirst = 1'($urandom_range(0, 1));
            sent = 0;
            if (cfirst) commit(l);
            while (sent < l) begin
                clk_en = ($urandom_range(0, 9) != 0);
                bus.tx_macread = ($urandom_range(0, 3) != 0);
                bus.data_wr_i = 1'($urandom_range(0, 1));
                bus.data_i = 8'($urandom);
                if (clk_en && bus.data_wr_i) sent++;
                tick();
            end
            bus.data_wr_i = 1'b0;
            clk_en = 1'b1;
            if (!cfirst) commit(l);
        end
        clk_en = 1'b1;
        bus.tx_macread = 1'b1;
        for (int c = 0; c < 8000 && remaining() > 0; c++) tick();
        for (int k = 0; k < 5; k++) tick();
        bus.tx_macread = 1'b0;
        check("rand_remaining", remaining(), 0);
        check("rand_frames", eof_cnt - e0, nz);
        check("rand_pending", bus.frames_pending_o, 0);
        check("rand_empty", bus.tx_fifoempty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
